// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline: drives the single-port data memory,
// holds the MEM/WB register and aligns/extends load data for writeback.
module mem_access_stage #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              ex_valid,
    input  logic [3:0]        ex_mem_op,
    input  logic [31:0]       ex_alu_res,
    input  logic [31:0]       ex_rt_data,
    input  logic [4:0]        ex_rd,
    input  logic              ex_w_reg_ena,
    input  logic              ex_wb_sel,
    output logic              mem_ena,
    output logic [3:0]        mem_wea,
    output logic [ADDR_W-1:0] mem_addra,
    output logic [31:0]       mem_dina,
    input  logic [31:0]       mem_douta,
    output logic              wb_valid,
    output logic [31:0]       wb_mem_data,
    output logic [31:0]       wb_alu_res,
    output logic [4:0]        wb_rd,
    output logic              wb_w_reg_ena,
    output logic              wb_wb_sel,
    output logic              wb_addr_err
);

    localparam logic [3:0] OP_NONE = 4'h0;
    localparam logic [3:0] OP_LB   = 4'h1;
    localparam logic [3:0] OP_LBU  = 4'h2;
    localparam logic [3:0] OP_LH   = 4'h3;
    localparam logic [3:0] OP_LHU  = 4'h4;
    localparam logic [3:0] OP_LW   = 4'h5;
    localparam logic [3:0] OP_SB   = 4'h9;
    localparam logic [3:0] OP_SH   = 4'hA;
    localparam logic [3:0] OP_SW   = 4'hB;

    logic        is_load_s;
    logic        is_store_s;
    logic        misalign_s;
    logic        req_ena_s;
    logic [3:0]  wea_s;
    logic [31:0] dina_s;
    logic [31:0] word_idx_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic [31:0] load_data_s;

    logic        valid_r;
    logic [31:0] alu_res_r;
    logic [4:0]  rd_r;
    logic        w_reg_ena_r;
    logic        wb_sel_r;
    logic [3:0]  op_r;
    logic [1:0]  offset_r;
    logic        addr_err_r;

    // Classify the EX/MEM op and check natural alignment
    always_comb begin
        is_load_s  = 1'b0;
        is_store_s = 1'b0;
        misalign_s = 1'b0;
        case (ex_mem_op)
            OP_LB, OP_LBU: begin
                is_load_s = 1'b1;
            end
            OP_LH, OP_LHU: begin
                is_load_s  = 1'b1;
                misalign_s = ex_alu_res[0];
            end
            OP_LW: begin
                is_load_s  = 1'b1;
                misalign_s = |ex_alu_res[1:0];
            end
            OP_SB: begin
                is_store_s = 1'b1;
            end
            OP_SH: begin
                is_store_s = 1'b1;
                misalign_s = ex_alu_res[0];
            end
            OP_SW: begin
                is_store_s = 1'b1;
                misalign_s = |ex_alu_res[1:0];
            end
            default: begin
                is_load_s  = 1'b0;
                is_store_s = 1'b0;
                misalign_s = 1'b0;
            end
        endcase
    end

    // Byte enables and lane-replicated write data for stores
    always_comb begin
        wea_s  = 4'b0000;
        dina_s = 32'h0000_0000;
        case (ex_mem_op)
            OP_SB: begin
                wea_s  = 4'b0001 << ex_alu_res[1:0];
                dina_s = {4{ex_rt_data[7:0]}};
            end
            OP_SH: begin
                wea_s  = ex_alu_res[1] ? 4'b1100 : 4'b0011;
                dina_s = {2{ex_rt_data[15:0]}};
            end
            OP_SW: begin
                wea_s  = 4'b1111;
                dina_s = ex_rt_data;
            end
            default: begin
                wea_s  = 4'b0000;
                dina_s = 32'h0000_0000;
            end
        endcase
    end

    // Reset gating keeps a store that is in flight when reset asserts from landing
    assign req_ena_s  = ex_valid & (is_load_s | is_store_s) & ~misalign_s & ~stall & ~rst;
    assign word_idx_s = {2'b00, ex_alu_res[31:2]};

    assign mem_ena   = req_ena_s;
    assign mem_wea   = req_ena_s ? wea_s : 4'b0000;
    assign mem_addra = word_idx_s[ADDR_W-1:0];
    assign mem_dina  = dina_s;

    // MEM/WB pipeline register, frozen while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r     <= 1'b0;
            alu_res_r   <= 32'h0000_0000;
            rd_r        <= 5'd0;
            w_reg_ena_r <= 1'b0;
            wb_sel_r    <= 1'b0;
            op_r        <= OP_NONE;
            offset_r    <= 2'd0;
            addr_err_r  <= 1'b0;
        end else if (!stall) begin
            valid_r     <= ex_valid;
            alu_res_r   <= ex_alu_res;
            rd_r        <= ex_rd;
            w_reg_ena_r <= ex_w_reg_ena & ex_valid & ~misalign_s;
            wb_sel_r    <= ex_wb_sel;
            op_r        <= ex_mem_op;
            offset_r    <= ex_alu_res[1:0];
            addr_err_r  <= ex_valid & misalign_s;
        end
    end

    // Lane selection for sub-word loads
    always_comb begin
        byte_s = 8'h00;
        case (offset_r)
            2'd0:    byte_s = mem_douta[7:0];
            2'd1:    byte_s = mem_douta[15:8];
            2'd2:    byte_s = mem_douta[23:16];
            2'd3:    byte_s = mem_douta[31:24];
            default: byte_s = 8'h00;
        endcase
        half_s = offset_r[1] ? mem_douta[31:16] : mem_douta[15:0];
    end

    // Sign/zero extension; faulted or non-load slots return zero
    always_comb begin
        load_data_s = 32'h0000_0000;
        if (addr_err_r) begin
            load_data_s = 32'h0000_0000;
        end else begin
            case (op_r)
                OP_LB:   load_data_s = {{24{byte_s[7]}}, byte_s};
                OP_LBU:  load_data_s = {24'h00_0000, byte_s};
                OP_LH:   load_data_s = {{16{half_s[15]}}, half_s};
                OP_LHU:  load_data_s = {16'h0000, half_s};
                OP_LW:   load_data_s = mem_douta;
                default: load_data_s = 32'h0000_0000;
            endcase
        end
    end

    assign wb_valid     = valid_r;
    assign wb_mem_data  = load_data_s;
    assign wb_alu_res   = alu_res_r;
    assign wb_rd        = rd_r;
    assign wb_w_reg_ena = w_reg_ena_r;
    assign wb_wb_sel    = wb_sel_r;
    assign wb_addr_err  = addr_err_r;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a behavioural 1-cycle-latency
// byte-enabled memory standing in for the Memory IP.
module tb_mem_access_stage;

    localparam logic [3:0] OP_NONE = 4'h0;
    localparam logic [3:0] OP_LB   = 4'h1;
    localparam logic [3:0] OP_LBU  = 4'h2;
    localparam logic [3:0] OP_LH   = 4'h3;
    localparam logic [3:0] OP_LHU  = 4'h4;
    localparam logic [3:0] OP_LW   = 4'h5;
    localparam logic [3:0] OP_SB   = 4'h9;
    localparam logic [3:0] OP_SH   = 4'hA;
    localparam logic [3:0] OP_SW   = 4'hB;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        ex_valid;
    logic [3:0]  ex_mem_op;
    logic [31:0] ex_alu_res;
    logic [31:0] ex_rt_data;
    logic [4:0]  ex_rd;
    logic        ex_w_reg_ena;
    logic        ex_wb_sel;
    logic        mem_ena;
    logic [3:0]  mem_wea;
    logic [31:0] mem_addra;
    logic [31:0] mem_dina;
    logic [31:0] mem_douta;
    logic        wb_valid;
    logic [31:0] wb_mem_data;
    logic [31:0] wb_alu_res;
    logic [4:0]  wb_rd;
    logic        wb_w_reg_ena;
    logic        wb_wb_sel;
    logic        wb_addr_err;

    int checks_cnt = 0;
    int errors_cnt = 0;

    logic [31:0] ram [0:15];

    mem_access_stage #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .ex_valid     (ex_valid),
        .ex_mem_op    (ex_mem_op),
        .ex_alu_res   (ex_alu_res),
        .ex_rt_data   (ex_rt_data),
        .ex_rd        (ex_rd),
        .ex_w_reg_ena (ex_w_reg_ena),
        .ex_wb_sel    (ex_wb_sel),
        .mem_ena      (mem_ena),
        .mem_wea      (mem_wea),
        .mem_addra    (mem_addra),
        .mem_dina     (mem_dina),
        .mem_douta    (mem_douta),
        .wb_valid     (wb_valid),
        .wb_mem_data  (wb_mem_data),
        .wb_alu_res   (wb_alu_res),
        .wb_rd        (wb_rd),
        .wb_w_reg_ena (wb_w_reg_ena),
        .wb_wb_sel    (wb_wb_sel),
        .wb_addr_err  (wb_addr_err)
    );

    // Clock generation
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory IP model: byte-write, read-first, one-cycle read latency
    always @(posedge clk) begin
        if (mem_ena) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_wea[i]) ram[mem_addra[3:0]][8*i +: 8] <= mem_dina[8*i +: 8];
            end
            mem_douta <= ram[mem_addra[3:0]];
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks_cnt++;
        if (act !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rt,
                         input logic [4:0] rd, input logic wreg, input logic wbsel);
        @(negedge clk);
        ex_valid     = 1'b1;
        ex_mem_op    = op;
        ex_alu_res   = addr;
        ex_rt_data   = rt;
        ex_rd        = rd;
        ex_w_reg_ena = wreg;
        ex_wb_sel    = wbsel;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        stall        = 1'b0;
        ex_valid     = 1'b0;
        ex_mem_op    = OP_NONE;
        ex_alu_res   = 32'h0;
        ex_rt_data   = 32'h0;
        ex_rd        = 5'd0;
        ex_w_reg_ena = 1'b0;
        ex_wb_sel    = 1'b0;
        mem_douta    = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_wb_valid", {31'b0, wb_valid}, 32'h0);
        check("rst_wb_wreg",  {31'b0, wb_w_reg_ena}, 32'h0);
        check("rst_wb_err",   {31'b0, wb_addr_err}, 32'h0);
        check("rst_wb_data",  wb_mem_data, 32'h0);
        check("rst_wb_rd",    {27'b0, wb_rd}, 32'h0);
        check("rst_mem_ena",  {31'b0, mem_ena}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // 1: word store
        drive(OP_SW, 32'h4, 32'h1234_5678, 5'd0, 1'b0, 1'b0);
        check("sw_ena",   {31'b0, mem_ena}, 32'h1);
        check("sw_wea",   {28'b0, mem_wea}, 32'hF);
        check("sw_addra", mem_addra, 32'h1);
        check("sw_dina",  mem_dina, 32'h1234_5678);
        step();
        check("sw_wb_wreg",  {31'b0, wb_w_reg_ena}, 32'h0);
        check("sw_wb_valid", {31'b0, wb_valid}, 32'h1);
        check("sw_wb_data",  wb_mem_data, 32'h0);

        // 2: sub-word loads of the stored word
        drive(OP_LB, 32'h5, 32'h0, 5'd7, 1'b1, 1'b1);
        check("lb5_wea", {28'b0, mem_wea}, 32'h0);
        step();
        check("lb5_data", wb_mem_data, 32'h0000_0056);
        check("lb5_wreg", {31'b0, wb_w_reg_ena}, 32'h1);
        check("lb5_rd",   {27'b0, wb_rd}, 32'd7);
        check("lb5_sel",  {31'b0, wb_wb_sel}, 32'h1);
        drive(OP_LB, 32'h7, 32'h0, 5'd8, 1'b1, 1'b1);
        step();
        check("lb7_data", wb_mem_data, 32'h0000_0012);
        drive(OP_LH, 32'h6, 32'h0, 5'd8, 1'b1, 1'b1);
        step();
        check("lh6_data", wb_mem_data, 32'h0000_1234);

        // 3: byte/half stores and sign handling
        drive(OP_SB, 32'h8, 32'h0000_0080, 5'd0, 1'b0, 1'b0);
        check("sb_wea",  {28'b0, mem_wea}, 32'h1);
        check("sb_dina", mem_dina, 32'h8080_8080);
        step();
        drive(OP_LB, 32'h8, 32'h0, 5'd9, 1'b1, 1'b1);
        step();
        check("lb8_data", wb_mem_data, 32'hFFFF_FF80);
        drive(OP_LBU, 32'h8, 32'h0, 5'd9, 1'b1, 1'b1);
        step();
        check("lbu8_data", wb_mem_data, 32'h0000_0080);
        drive(OP_SH, 32'hA, 32'h0000_BEEF, 5'd0, 1'b0, 1'b0);
        check("sh_wea",   {28'b0, mem_wea}, 32'hC);
        check("sh_dina",  mem_dina, 32'hBEEF_BEEF);
        check("sh_addra", mem_addra, 32'h2);
        step();
        drive(OP_LHU, 32'hA, 32'h0, 5'd10, 1'b1, 1'b1);
        step();
        check("lhua_data", wb_mem_data, 32'h0000_BEEF);
        drive(OP_LH, 32'hA, 32'h0, 5'd10, 1'b1, 1'b1);
        step();
        check("lha_data", wb_mem_data, 32'hFFFF_BEEF);
        drive(OP_SB, 32'hB, 32'h0000_0011, 5'd0, 1'b0, 1'b0);
        check("sb3_wea", {28'b0, mem_wea}, 32'h8);
        step();

        // 4: misaligned accesses
        drive(OP_LW, 32'h6, 32'h0, 5'd11, 1'b1, 1'b1);
        check("lw6_ena", {31'b0, mem_ena}, 32'h0);
        check("lw6_wea", {28'b0, mem_wea}, 32'h0);
        step();
        check("lw6_err",  {31'b0, wb_addr_err}, 32'h1);
        check("lw6_wreg", {31'b0, wb_w_reg_ena}, 32'h0);
        check("lw6_data", wb_mem_data, 32'h0);
        drive(OP_SH, 32'h5, 32'h0000_AAAA, 5'd0, 1'b0, 1'b0);
        check("sh5_ena", {31'b0, mem_ena}, 32'h0);
        check("sh5_wea", {28'b0, mem_wea}, 32'h0);
        step();
        check("sh5_err", {31'b0, wb_addr_err}, 32'h1);

        // non-memory op passes ALU result through
        drive(OP_NONE, 32'h0000_0007, 32'h0, 5'd12, 1'b1, 1'b0);
        check("none_ena", {31'b0, mem_ena}, 32'h0);
        step();
        check("none_alu",  wb_alu_res, 32'h0000_0007);
        check("none_wreg", {31'b0, wb_w_reg_ena}, 32'h1);
        check("none_err",  {31'b0, wb_addr_err}, 32'h0);
        check("none_data", wb_mem_data, 32'h0);

        // 5: load held stable across a stall
        drive(OP_LW, 32'h4, 32'h0, 5'd13, 1'b1, 1'b1);
        step();
        check("lw4_data", wb_mem_data, 32'h1234_5678);
        drive(OP_LB, 32'h8, 32'h0, 5'd3, 1'b0, 1'b0);
        stall = 1'b1;
        #1;
        check("stall_ena", {31'b0, mem_ena}, 32'h0);
        for (int c = 0; c < 3; c++) begin
            step();
            check("stall_data",  wb_mem_data, 32'h1234_5678);
            check("stall_rd",    {27'b0, wb_rd}, 32'd13);
            check("stall_alu",   wb_alu_res, 32'h4);
            check("stall_wreg",  {31'b0, wb_w_reg_ena}, 32'h1);
            check("stall_valid", {31'b0, wb_valid}, 32'h1);
            check("stall_ena2",  {31'b0, mem_ena}, 32'h0);
        end
        @(negedge clk);
        stall    = 1'b0;
        ex_valid = 1'b0;

        // 6: reset mid-cycle aborts a store
        drive(OP_SW, 32'hC, 32'hCAFE_F00D, 5'd0, 1'b0, 1'b0);
        step();
        drive(OP_LW, 32'h4, 32'h0, 5'd14, 1'b1, 1'b1);
        step();
        drive(OP_SW, 32'hC, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0);
        check("pre_rst_ena",  {31'b0, mem_ena}, 32'h1);
        check("pre_rst_data", wb_mem_data, 32'h1234_5678);
        rst = 1'b1;
        #1;
        check("rst_ena",   {31'b0, mem_ena}, 32'h0);
        check("rst_wea",   {28'b0, mem_wea}, 32'h0);
        check("rst_valid", {31'b0, wb_valid}, 32'h0);
        check("rst_alu",   wb_alu_res, 32'h0);
        check("rst_data",  wb_mem_data, 32'h0);
        check("rst_rd",    {27'b0, wb_rd}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst      = 1'b0;
        ex_valid = 1'b0;
        drive(OP_LW, 32'hC, 32'h0, 5'd15, 1'b1, 1'b1);
        step();
        check("lwc_data", wb_mem_data, 32'hCAFE_F00D);
        @(negedge clk);
        ex_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
